input_log_uploader: RTL
=======================

# input_log_uploader

Records changes of player-1 joystick and analog state into an on-chip ring buffer, stamped with a video frame counter. On a HPS upload request for its ioctl index, it serves the log back as a byte stream on `ioctl_din`, using `ioctl_wait` as the flow-control handshake. It sits in `emu` beside `soc` and is the HPS-bound counterpart of the ROM download path.

## Interface
Parameters:
- `ADDR_W`, 8: log depth is 2^ADDR_W entries. Legal range 4..15.
- `UPLOAD_INDEX`, 8'd3: `ioctl_index` value this block answers.

Ports:
- `clk_sys` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `vs` in 1: vertical sync, active-high, synchronous to `clk_sys`.
- `log_en` in 1: capture enable.
- `clear` in 1: single-cycle pulse; empties the log.
- `joystick` in 32: `joystick_0`.
- `joystick_analog` in 16: `joystick_analog_0`.
- `ioctl_upload` in 1: upload active.
- `ioctl_index` in 8: selected upload index.
- `ioctl_rd` in 1: single-cycle byte request for `ioctl_addr`.
- `ioctl_addr` in 25: byte address.
- `ioctl_din` out 8: requested byte.
- `ioctl_wait` out 1: high while a read is pending.
- `log_count` out ADDR_W+1: valid entries, saturating at 2^ADDR_W.
- `log_overflow` out 1: sticky; set when an entry is overwritten.

## Operation
- `up_sel = ioctl_upload && ioctl_index == UPLOAD_INDEX`.

**Frame counter**
- 16-bit `frame`, increments on each `vs` rising edge.
- Wraps from 0xFFFF to 0.

**Capture**
- Active when `log_en && !up_sel && !clear`.
- Each cycle, compare `{joystick_analog, joystick}` with register `last`. On a difference:
  - write entry `{frame, joystick_analog, joystick}` (64 bits) at `wr_ptr`;
  - `last` <= the new value;
  - `wr_ptr` increments and wraps at 2^ADDR_W;
  - `log_count` increments and saturates.
- Write while full: the oldest entry is overwritten and `log_overflow` is set.
- `oldest = full ? wr_ptr : 0`.
- `clear`: zeroes `wr_ptr`, `log_count`, `log_overflow` and `last`. It takes priority over a same-cycle capture.
- Capture is frozen while `up_sel` is high, so the uploaded image is consistent.

**Upload image** (little-endian fields)
- Bytes 0–3: 0x49 0x4E 0x50 0x4C ("INPL").
- Byte 4: ADDR_W.
- Byte 5: `{7'b0, log_overflow}`.
- Bytes 6–7: `log_count`.
- Entry k (0 = oldest) occupies bytes 8+8k .. 15+8k, in this order:
  - timestamp (2 bytes);
  - analog (2 bytes);
  - joystick (4 bytes).
- Physical slot = (oldest + k) mod 2^ADDR_W.
- Any address ≥ 8 + 8·`log_count`: returns 0x00.

**Read FSM**
- IDLE: on `ioctl_rd && up_sel`, latch the address, present the BRAM address, go to FETCH. A header address or out-of-range address skips the BRAM access.
- FETCH: BRAM data returns; select byte `addr[2:0]`; go to DONE.
- DONE: drive `ioctl_din`; go to IDLE.
- `ioctl_rd` while not `up_sel`: ignored.
- `ioctl_rd` while not IDLE: protocol error; ignored.
- `up_sel` falling mid-read: the read completes normally.

## Timing
- Reset values:
  - `ioctl_din` = 0, `ioctl_wait` = 0;
  - `log_count` = 0, `log_overflow` = 0;
  - `frame` = 0, `wr_ptr` = 0, `last` = 0;
  - FSM = IDLE.
- Buffer contents are not reset.
- Read handshake:
  - `ioctl_rd` arrives at cycle 0.
  - `ioctl_wait` is high combinationally in cycle 0 and registered high in cycle 1.
  - In cycle 2, `ioctl_din` is valid and `ioctl_wait` is low.
  - `ioctl_din` holds until the next accepted read.
- Capture latency: an input change in cycle n is written in cycle n. `log_count` updates in cycle n+1.
- A `vs` edge and a capture in the same cycle: the entry carries the pre-increment `frame`.
- Reset mid-read: FSM returns to IDLE next cycle and `ioctl_wait` drops.
- Because capture is frozen during `up_sel`, no read/write collision on the same BRAM slot is possible.

## Structure
- Package `input_log_pkg`:
  - `LOG_MAGIC` (32-bit);
  - `HDR_BYTES = 8`, `ENTRY_BYTES = 8`;
  - typedef `log_entry_t` (packed `frame`/`analog`/`joy`);
  - FSM state enum.
- Sub-module: `dpram` (simple dual-port, 64-bit × 2^ADDR_W, one write port, one registered read port). All other logic is in this module.

## Test plan
- Reset, then upload and read bytes 0–7 -> 49 4E 50 4C 08 00 00 00; each read shows 2-cycle latency with `ioctl_wait` high in cycles 0–1.
- Set joystick = 0x00000010 at frame 5 and analog = 0x7F80 at frame 7; read bytes 8–23 -> 05 00 00 00 10 00 00 00, then 07 00 80 7F 10 00 00 00; byte 24 -> 00.
- ADDR_W=4: log 20 distinct values v0..v19 -> `log_count` = 16, `log_overflow` = 1, byte 5 = 01; entry 0 = v4, entry 15 = v19.
- `clear` in the same cycle as an input change -> `log_count` stays 0 and no entry is written; the next change logs at entry 0.
- Input changes while `up_sel` is high -> not logged; `ioctl_rd` with `ioctl_index` = 1 -> `ioctl_wait` stays 0 and `ioctl_din` is unchanged.
- Assert `reset` in FETCH -> `ioctl_wait` = 0 next cycle, `ioctl_din` = 0, `log_count` = 0.

Source files
------------

// File: rtl/input_log_pkg.sv
// Shared types and constants for the input log uploader: image header layout,
// log entry format and read-side state encodings.
package input_log_pkg;

   localparam logic [31:0] LOG_MAGIC   = 32'h4C50_4E49;
   localparam int          HDR_BYTES   = 8;
   localparam int          ENTRY_BYTES = 8;

   typedef struct packed {
      logic [15:0] frame;
      logic [15:0] analog;
      logic [31:0] joy;
   } log_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DONE
   } rd_state_t;

   typedef enum logic [1:0] {
      SRC_HDR,
      SRC_ENTRY,
      SRC_ZERO
   } rd_src_t;

   // Reorders an entry into its upload byte order: timestamp, analog, joystick.
   function automatic logic [63:0] entry_le(input log_entry_t e);
      return {e.joy, e.analog, e.frame};
   endfunction

endpackage

// File: rtl/input_log_uploader_if.sv
// HPS ioctl upload channel: the HPS side drives the request, the log block
// answers with the data byte and the wait handshake.
interface input_log_uploader_if;

   logic        ioctl_upload;
   logic [7:0]  ioctl_index;
   logic        ioctl_rd;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;

   modport master (
      output ioctl_upload,
      output ioctl_index,
      output ioctl_rd,
      output ioctl_addr,
      input  ioctl_din,
      input  ioctl_wait
   );

   modport slave (
      input  ioctl_upload,
      input  ioctl_index,
      input  ioctl_rd,
      input  ioctl_addr,
      output ioctl_din,
      output ioctl_wait
   );

endinterface

// File: rtl/input_log_uploader_dpram.sv
// Simple dual-port RAM: one write port and one registered, enabled read port.
// Contents are intentionally not reset so it maps onto block RAM.
module dpram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/input_log_uploader.sv
// Logs player-1 joystick/analog changes with a frame timestamp into a ring
// buffer and serves the log image to the HPS over the ioctl upload channel.
module input_log_uploader
   import input_log_pkg::*;
#(
   parameter int          ADDR_W       = 8,
   parameter logic [7:0]  UPLOAD_INDEX = 8'd3
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   input  logic                 vs,
   input  logic                 log_en,
   input  logic                 clear,
   input  logic [31:0]          joystick,
   input  logic [15:0]          joystick_analog,
   input_log_uploader_if.slave  ioctl,
   output logic [ADDR_W:0]      log_count,
   output logic                 log_overflow
);

   localparam int              DEPTH      = 1 << ADDR_W;
   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

   logic              vs_d;
   logic [15:0]       frame;
   logic [47:0]       last;
   logic [ADDR_W-1:0] wr_ptr;
   logic              up_sel;
   logic              full;
   logic              cap_we;
   log_entry_t        wr_entry;

   assign up_sel   = ioctl.ioctl_upload && (ioctl.ioctl_index == UPLOAD_INDEX);
   assign full     = (log_count == FULL_COUNT);
   assign cap_we   = log_en && !up_sel && !clear && ({joystick_analog, joystick} != last);
   assign wr_entry = {frame, joystick_analog, joystick};

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         vs_d  <= 1'b0;
         frame <= 16'd0;
      end else begin
         vs_d <= vs;
         if (vs && !vs_d) begin
            frame <= frame + 16'd1;
         end
      end
   end

   // Once full, every new entry lands on the oldest slot, so the count stays
   // pinned and the overflow flag records that history was lost.
   always_ff @(posedge clk_sys) begin
      if (reset || clear) begin
         last         <= '0;
         wr_ptr       <= '0;
         log_count    <= '0;
         log_overflow <= 1'b0;
      end else if (cap_we) begin
         last   <= {joystick_analog, joystick};
         wr_ptr <= wr_ptr + ADDR_W'(1);
         if (full) begin
            log_overflow <= 1'b1;
         end else begin
            log_count <= log_count + (ADDR_W+1)'(1);
         end
      end
   end

   // Read-side address decode
   logic              accept;
   logic              is_hdr;
   logic              in_range;
   logic [25:0]       limit;
   logic [ADDR_W-1:0] oldest;
   logic [ADDR_W-1:0] entry_k;
   logic [ADDR_W-1:0] rd_slot;
   logic              bram_re;
   logic [63:0]       bram_rdata;
   log_entry_t        rd_entry;
   logic [63:0]       rd_le;
   logic [63:0]       hdr_word;

   rd_state_t state, state_next;
   rd_src_t   src_r, src_next;
   logic [2:0] sel_r, sel_next;
   logic [7:0] din_r, din_next;
   logic       wait_c;

   assign accept   = (state == ST_IDLE) && ioctl.ioctl_rd && up_sel && !reset;
   assign is_hdr   = (ioctl.ioctl_addr[24:3] == '0);
   assign limit    = 26'(HDR_BYTES) + (26'(log_count) << 3);
   assign in_range = !is_hdr && ({1'b0, ioctl.ioctl_addr} < limit);
   assign oldest   = full ? wr_ptr : '0;
   assign entry_k  = ioctl.ioctl_addr[ADDR_W+2:3] - ADDR_W'(1);
   assign rd_slot  = oldest + entry_k;
   assign rd_entry = bram_rdata;
   assign rd_le    = entry_le(rd_entry);
   assign hdr_word = {16'(log_count), 7'b0, log_overflow, 8'(ADDR_W), LOG_MAGIC};

   dpram #(
      .ADDR_W (ADDR_W),
      .DATA_W (64)
   ) u_ram (
      .clk   (clk_sys),
      .we    (cap_we),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .re    (bram_re),
      .raddr (rd_slot),
      .rdata (bram_rdata)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state <= ST_IDLE;
         src_r <= SRC_HDR;
         sel_r <= 3'd0;
         din_r <= 8'd0;
      end else begin
         state <= state_next;
         src_r <= src_next;
         sel_r <= sel_next;
         din_r <= din_next;
      end
   end

   // Wait is raised combinationally on the accepting cycle so the HPS sees it
   // before its next sample, and held through FETCH while RAM data returns.
   always_comb begin
      state_next = state;
      src_next   = src_r;
      sel_next   = sel_r;
      din_next   = din_r;
      wait_c     = 1'b0;
      bram_re    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               wait_c     = 1'b1;
               bram_re    = in_range;
               sel_next   = ioctl.ioctl_addr[2:0];
               src_next   = is_hdr ? SRC_HDR : (in_range ? SRC_ENTRY : SRC_ZERO);
               state_next = ST_FETCH;
            end
         end
         ST_FETCH: begin
            wait_c = 1'b1;
            case (src_r)
               SRC_HDR:   din_next = hdr_word[{sel_r, 3'b000} +: 8];
               SRC_ENTRY: din_next = rd_le[{sel_r, 3'b000} +: 8];
               default:   din_next = 8'd0;
            endcase
            state_next = ST_DONE;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign ioctl.ioctl_din  = din_r;
   assign ioctl.ioctl_wait = wait_c;

endmodule
